// File: rtl/pc_ir_unit.sv
// PC / IR stage of the 16-bit RISC datapath: PC update, IR capture, memory address mux.
// Optional jump-trace buffer compiled in with `define PC_TRACE_EN.
module pc_ir_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_ld,
   input  logic        pc_inc,
   input  logic        pc_sel,
   input  logic        ir_ld,
   input  logic        adr_sel,
   input  logic [15:0] mem_dout,
   input  logic [15:0] r_bus,
   input  logic [15:0] s_bus,
   output logic [15:0] address,
   output logic [15:0] pc,
   output logic [15:0] ir,
   output logic [15:0] fetch_count,
   input  logic [1:0]  trace_sel,
   output logic [15:0] trace_pc,
   output logic [2:0]  trace_cnt
);

   logic [15:0] pc_r;
   logic [15:0] ir_r;
   logic [15:0] fetch_count_r;
   logic [15:0] pc_next_s;
   logic [15:0] branch_target_s;

   // Next-PC selection: load beats increment; branch offset is relative to the current PC.
   always_comb begin
      branch_target_s = pc_r + {{8{ir_r[7]}}, ir_r[7:0]};
      pc_next_s       = pc_r;
      if (pc_ld) begin
         if (pc_sel) begin
            pc_next_s = s_bus;
         end else begin
            pc_next_s = branch_target_s;
         end
      end else if (pc_inc) begin
         pc_next_s = pc_r + 16'd1;
      end else begin
         pc_next_s = pc_r;
      end
   end

   // PC, IR and saturating fetch counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r          <= 16'h0000;
         ir_r          <= 16'h0000;
         fetch_count_r <= 16'h0000;
      end else begin
         pc_r <= pc_next_s;
         if (ir_ld) begin
            ir_r <= mem_dout;
            if (fetch_count_r != 16'hFFFF) begin
               fetch_count_r <= fetch_count_r + 16'd1;
            end
         end
      end
   end

   assign pc          = pc_r;
   assign ir          = ir_r;
   assign fetch_count = fetch_count_r;
   assign address     = adr_sel ? r_bus : pc_r;

`ifdef PC_TRACE_EN
   logic [15:0] trace_mem_r [4];
   logic [1:0]  trace_wr_ptr_r;
   logic [2:0]  trace_cnt_r;
   logic [1:0]  trace_rd_idx_s;

   // Circular trace of pre-jump PCs; the write pointer always names the slot after the newest.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            trace_mem_r[i] <= 16'h0000;
         end
         trace_wr_ptr_r <= 2'd0;
         trace_cnt_r    <= 3'd0;
      end else if (pc_ld) begin
         trace_mem_r[trace_wr_ptr_r] <= pc_r;
         trace_wr_ptr_r              <= trace_wr_ptr_r + 2'd1;
         if (trace_cnt_r != 3'd4) begin
            trace_cnt_r <= trace_cnt_r + 3'd1;
         end
      end
   end

   // Age-indexed read; ages not yet written read as zero.
   always_comb begin
      trace_rd_idx_s = trace_wr_ptr_r - 2'd1 - trace_sel;
      if ({1'b0, trace_sel} < trace_cnt_r) begin
         trace_pc = trace_mem_r[trace_rd_idx_s];
      end else begin
         trace_pc = 16'h0000;
      end
   end

   assign trace_cnt = trace_cnt_r;
`else
   logic unused_trace_sel_s;

   assign unused_trace_sel_s = ^trace_sel;
   assign trace_pc           = 16'h0000;
   assign trace_cnt          = 3'd0;
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed table-driven bench for pc_ir_unit, plus hand sequences for reset timing and trace.
module tb_pc_ir_unit;

   typedef struct packed {
      logic        rst;
      logic        ld;
      logic        inc;
      logic        sel;
      logic        irld;
      logic        asel;
      logic [15:0] mem;
      logic [15:0] rbus;
      logic [15:0] sbus;
      logic [15:0] e_pc;
      logic [15:0] e_ir;
      logic [15:0] e_fc;
      logic [15:0] e_adr;
   } vec_t;

   localparam int NVEC = 21;

   logic        clk = 1'b0;
   logic        reset, pc_ld, pc_inc, pc_sel, ir_ld, adr_sel;
   logic [15:0] mem_dout, r_bus, s_bus;
   logic [15:0] address, pc, ir, fetch_count, trace_pc;
   logic [1:0]  trace_sel;
   logic [2:0]  trace_cnt;

   int checks = 0;
   int errors = 0;
   vec_t vecs [NVEC];

   pc_ir_unit dut (
      .clk(clk), .reset(reset), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel),
      .ir_ld(ir_ld), .adr_sel(adr_sel), .mem_dout(mem_dout), .r_bus(r_bus),
      .s_bus(s_bus), .address(address), .pc(pc), .ir(ir), .fetch_count(fetch_count),
      .trace_sel(trace_sel), .trace_pc(trace_pc), .trace_cnt(trace_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic idle();
      reset = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0; pc_sel = 1'b0;
      ir_ld = 1'b0; adr_sel = 1'b0;
   endtask

   task automatic jump(input logic [15:0] tgt);
      @(negedge clk);
      idle();
      pc_ld = 1'b1; pc_sel = 1'b1; s_bus = tgt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             rst   ld    inc   sel   irld  asel  mem       rbus      sbus      pc        ir        fc        adr
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd0, 16'h0000};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hE0C1, 16'h0000, 16'h0000, 16'h0001, 16'hE0C1, 16'd1, 16'h0001};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 16'hE0C1, 16'd1, 16'h0010};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF8FD, 16'h0000, 16'h0000, 16'h0010, 16'hF8FD, 16'd2, 16'h0010};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h000D, 16'hF8FD, 16'd2, 16'h000D};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h000D, 16'h0005, 16'd3, 16'h000D};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 16'h0005, 16'd3, 16'h0010};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0015, 16'h0005, 16'd3, 16'h0015};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 16'h0005, 16'd3, 16'h1234};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0005, 16'd3, 16'hFFFF};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'd3, 16'h0000};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00FC, 16'h0000, 16'h0000, 16'h0001, 16'h00FC, 16'd4, 16'h0001};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h00FC, 16'd4, 16'h0002};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 16'h00FC, 16'd4, 16'hFFFE};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 16'hFFFA, 16'h0003, 16'd5, 16'hFFFA};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0000, 16'h5555, 16'hFFFA, 16'h0003, 16'd5, 16'hFFFA};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0040, 16'h0040, 16'h0003, 16'd5, 16'h0040};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200, 16'h0000, 16'h0040, 16'h0003, 16'd5, 16'h0200};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0200, 16'h0000, 16'h0040, 16'h0003, 16'd5, 16'h0040};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0123, 16'h0123, 16'h0003, 16'd5, 16'h0123};
      vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd0, 16'h0000};

      idle();
      mem_dout = 16'h0000; r_bus = 16'h0000; s_bus = 16'h0000; trace_sel = 2'd0;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         reset = vecs[i].rst; pc_ld = vecs[i].ld; pc_inc = vecs[i].inc; pc_sel = vecs[i].sel;
         ir_ld = vecs[i].irld; adr_sel = vecs[i].asel;
         mem_dout = vecs[i].mem; r_bus = vecs[i].rbus; s_bus = vecs[i].sbus;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d ir", i), ir, vecs[i].e_ir);
         chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_fc);
         chk($sformatf("v%0d address", i), address, vecs[i].e_adr);
      end

      // Address mux reacts between edges with no register in the path.
      @(negedge clk);
      idle();
      r_bus = 16'h0ABC; adr_sel = 1'b1;
      #1;
      chk("addr_zero_latency", address, 16'h0ABC);
      adr_sel = 1'b0;
      #1;
      chk("addr_back_to_pc", address, 16'h0000);

      // Reset raised between edges only acts at the next edge.
      @(negedge clk);
      idle();
      pc_inc = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_reset_pc", pc, 16'h0001);
      @(negedge clk);
      idle();
      #2;
      reset = 1'b1;
      #1;
      chk("reset_mid_cycle_no_effect", pc, 16'h0001);
      @(posedge clk);
      #1;
      chk("reset_at_edge_pc", pc, 16'h0000);
      chk("reset_trace_cnt", {13'd0, trace_cnt}, 16'd0);

      // Trace: five jumps taken from PCs 1..5.
      @(negedge clk);
      idle();
      pc_inc = 1'b1;
      @(posedge clk);
      #1;
      jump(16'h0002);
      jump(16'h0003);
`ifdef PC_TRACE_EN
      trace_sel = 2'd1;
      #1;
      chk("trace_partial_cnt", {13'd0, trace_cnt}, 16'd2);
      chk("trace_partial_age1", trace_pc, 16'h0001);
      trace_sel = 2'd2;
      #1;
      chk("trace_partial_age2_empty", trace_pc, 16'h0000);
`endif
      jump(16'h0004);
      jump(16'h0005);
      jump(16'h0006);
      @(negedge clk);
      idle();
      trace_sel = 2'd0;
      #1;
`ifdef PC_TRACE_EN
      chk("trace_cnt_sat", {13'd0, trace_cnt}, 16'd4);
      chk("trace_age0", trace_pc, 16'h0005);
      trace_sel = 2'd3;
      #1;
      chk("trace_age3", trace_pc, 16'h0002);
      trace_sel = 2'd1;
      #1;
      chk("trace_age1", trace_pc, 16'h0004);
`else
      chk("trace_cnt_off", {13'd0, trace_cnt}, 16'd0);
      chk("trace_pc_off_sel0", trace_pc, 16'h0000);
      trace_sel = 2'd3;
      #1;
      chk("trace_pc_off_sel3", trace_pc, 16'h0000);
`endif
      chk("trace_final_pc", pc, 16'h0006);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
